// File: rtl/sgdlr_sdiv_44s_16s_28_seq.sv
// Sequential signed divider: 44-bit dividend / 16-bit divisor, 28-bit quotient.
// Restoring shift-subtract on magnitudes, one quotient bit per ce cycle.
// The quotient saturates on overflow, and a zero divisor is flagged.
// Fixed latency: out_valid rises 46 ce-enabled cycles after the accepting edge.
module sgdlr_sdiv_44s_16s_28_seq #(
  parameter ID        = 32'd1,
  parameter NUM_STAGE = 32'd46
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [43:0] din0,
  input  logic [15:0] din1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [27:0] dout,
  output logic [15:0] rem,
  output logic        ovf,
  output logic        dbz
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [5:0]  ITERS   = 6'd44;
  localparam logic [43:0] POS_MAX = 44'd134217727;  // 2^27 - 1
  localparam logic [43:0] NEG_MAX = 44'd134217728;  // 2^27
  localparam logic [27:0] Q_POS_SAT = 28'h7FFFFFF;
  localparam logic [27:0] Q_NEG_SAT = 28'h8000000;

  state_t      state, state_nxt;
  logic [43:0] dvd_q;     // dividend magnitude; quotient bits shift in from the LSB
  logic [15:0] dvs_q;     // divisor magnitude
  logic [15:0] r_q;       // partial remainder, always < dvs_q
  logic        sign_a, sign_b, zero_b;
  logic [5:0]  cnt;

  logic [16:0] r_sh;
  logic        r_ge;
  logic [15:0] r_nxt;
  logic        iter_done;

  logic [27:0] fix_dout;
  logic [15:0] fix_rem;
  logic        fix_ovf;

  // The counter reaches 44 after the last iteration. The CALC cycle that sees 44
  // hands off to FIX, which gives the 46-cycle latency for every operand.
  assign iter_done = (cnt == ITERS);

  // One restoring step: shift in the next dividend bit and subtract if it fits.
  always_comb begin
    r_sh  = {r_q, dvd_q[43]};
    r_ge  = (r_sh >= {1'b0, dvs_q});
    // The difference is below dvs_q, so a 16-bit wrapping subtract is exact.
    r_nxt = r_ge ? (r_sh[15:0] - dvs_q) : r_sh[15:0];
  end

  // Apply signs, saturate the quotient, and handle a zero divisor.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    fix_dout = dvd_q[27:0];
    fix_ovf  = 1'b0;
    fix_rem  = sign_a ? (16'd0 - r_q) : r_q;
    if (zero_b) begin
      fix_dout = sign_a ? Q_NEG_SAT : Q_POS_SAT;
      fix_rem  = 16'd0;
    end else if (sign_a ^ sign_b) begin
      if (dvd_q > NEG_MAX) begin
        fix_dout = Q_NEG_SAT;
        fix_ovf  = 1'b1;
      end else begin
        fix_dout = 28'd0 - dvd_q[27:0];
      end
    end else if (dvd_q > POS_MAX) begin
      fix_dout = Q_POS_SAT;
      fix_ovf  = 1'b1;
    end
  end

  // State register: synchronous reset, advances only on ce.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    if (reset)   state <= IDLE;
    else if (ce) state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = CALC;
      CALC:    if (iter_done) state_nxt = FIX;
      FIX:                    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Handshake outputs, decoded from state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath: capture operands, iterate, then register the fixed-up result.
  always_ff @(posedge clk) begin
    if (reset) begin
      dvd_q  <= '0;
      dvs_q  <= '0;
      r_q    <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      zero_b <= 1'b0;
      cnt    <= '0;
      dout   <= '0;
      rem    <= '0;
      ovf    <= 1'b0;
      dbz    <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE: if (in_valid) begin
          dvd_q  <= din0[43] ? (44'd0 - din0) : din0;
          dvs_q  <= din1[15] ? (16'd0 - din1) : din1;
          r_q    <= '0;
          sign_a <= din0[43];
          sign_b <= din1[15];
          zero_b <= (din1 == 16'd0);
          cnt    <= '0;
        end
        CALC: if (!iter_done) begin
          r_q   <= r_nxt;
          dvd_q <= {dvd_q[42:0], r_ge};
          cnt   <= cnt + 6'd1;
        end
        FIX: begin
          dout <= fix_dout;
          rem  <= fix_rem;
          ovf  <= fix_ovf;
          dbz  <= zero_b;
        end
        default: ;
      endcase
    end
  end

endmodule
